// File: rtl/display_timing_if.sv
// Panel timing bundle: driven by display_timing_gen, consumed by the LCD pins and the
// pixel renderer that supplies data in step with pix_x/pix_y/pix_tick.
interface display_timing_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           disp_clk;
  logic           disp_en;
  logic           disp_hsync;
  logic           disp_vsync;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           pix_tick;
  logic           frame_start;

  modport master (
    output disp_clk, disp_en, disp_hsync, disp_vsync,
    output pix_x, pix_y, pix_tick, frame_start
  );

  modport slave (
    input disp_clk, disp_en, disp_hsync, disp_vsync,
    input pix_x, pix_y, pix_tick, frame_start
  );
endinterface

// File: rtl/display_timing_gen.sv
// Parametrised RGB-panel timing generator: divides clk into pixel periods and walks a
// (d, h, v) counter chain, registering panel signals decoded from the next state.
module display_timing_gen #(
  parameter int H_ACTIVE  = 480,
  parameter int H_FRONT   = 2,
  parameter int H_SYNC    = 41,
  parameter int H_BACK    = 2,
  parameter int V_ACTIVE  = 272,
  parameter int V_FRONT   = 2,
  parameter int V_SYNC    = 10,
  parameter int V_BACK    = 2,
  parameter int CLK_DIV   = 6,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit DCLK_POL  = 1'b0,
  parameter int X_W       = 10,
  parameter int Y_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  display_timing_if.master  disp
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int D_W     = $clog2(CLK_DIV);
  localparam int H_W     = $clog2(H_TOTAL + 1);
  localparam int V_W     = $clog2(V_TOTAL + 1);

  localparam logic [D_W-1:0] D_LAST     = D_W'(CLK_DIV - 1);
  localparam logic [D_W-1:0] D_HALF     = D_W'(CLK_DIV / 2);
  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FRONT);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FRONT);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [D_W-1:0] d, d_next;
  logic [H_W-1:0] h, h_next;
  logic [V_W-1:0] v, v_next;
  logic           d_wrap, h_wrap, v_wrap;

  assign d_wrap = (d == D_LAST);
  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  // Enabled next state; the idle state is the frame's last cycle, so it wraps to (0,0,0).
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    d_next = d + 1'b1;
    h_next = h;
    v_next = v;
    if (d_wrap) begin
      d_next = '0;
      h_next = h_wrap ? '0 : h + 1'b1;
      if (h_wrap) v_next = v_wrap ? '0 : v + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      d                <= D_LAST;
      h                <= H_LAST;
      v                <= V_LAST;
      disp.disp_clk    <= DCLK_POL;
      disp.disp_en     <= 1'b0;
      disp.disp_hsync  <= ~HSYNC_POL;
      disp.disp_vsync  <= ~VSYNC_POL;
      disp.pix_tick    <= 1'b0;
      disp.frame_start <= 1'b0;
      disp.pix_x       <= X_W'(H_LAST);
      disp.pix_y       <= Y_W'(V_LAST);
    end else begin
      d                <= d_next;
      h                <= h_next;
      v                <= v_next;
      // Low phase is the first CLK_DIV/2 cycles, so the unpolarised rising edge is mid-pixel.
      disp.disp_clk    <= DCLK_POL ^ (d_next >= D_HALF);
      disp.disp_en     <= (h_next < H_ACT) && (v_next < V_ACT);
      disp.disp_hsync  <= ((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
      disp.disp_vsync  <= ((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
      disp.pix_tick    <= (d_next == '0);
      disp.frame_start <= (d_next == '0) && (h_next == '0) && (v_next == '0);
      disp.pix_x       <= X_W'(h_next);
      disp.pix_y       <= Y_W'(v_next);
    end
  end
endmodule
